// File: rtl/rv32im_dmem.sv
// rv32im_dmem: LSU data-memory responder with a configurable wait-state model.
// One request in flight; byte/half/word accesses on a little-endian word array.

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif
`ifndef LSU_NONE
`define LSU_NONE 4'd0
`define LSU_LB   4'd1
`define LSU_LH   4'd2
`define LSU_LW   4'd3
`define LSU_LBU  4'd4
`define LSU_LHU  4'd5
`define LSU_SB   4'd6
`define LSU_SH   4'd7
`define LSU_SW   4'd8
`endif

module rv32im_dmem #(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           req_i,
    input  logic [`LSU_OPCODE_WIDTH-1:0]   lsu_opcode_i,
    input  logic [`API_DATA_WIDTH-1:0]     val_memaddr_i,
    input  logic [`API_DATA_WIDTH-1:0]     val_memdatawr_i,
    output logic [`API_DATA_WIDTH-1:0]     val_memdatard_o,
    output logic                           ack_o,
    output logic                           err_o,
    output logic                           busy_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                         state_q;
    logic [CNT_WIDTH-1:0]           cnt_q;
    logic [`LSU_OPCODE_WIDTH-1:0]   op_q;
    logic [31:0]                    addr_q;
    logic [31:0]                    wdata_q;
    logic                           ack_q;
    logic                           err_q;
    logic                           busy_q;
    logic [31:0]                    rdata_q;

    logic [31:0] mem [DEPTH];

    logic                           accept;
    logic                           enter_resp;
    logic [`LSU_OPCODE_WIDTH-1:0]   cur_op;
    logic [31:0]                    cur_addr;
    logic [31:0]                    cur_wdata;
    logic                           is_half;
    logic                           is_word;
    logic                           is_store;
    logic                           sign_ext;
    logic                           misaligned;
    logic                           out_of_range;
    logic                           cur_err;
    logic [IdxW-1:0]                word_idx;
    logic [31:0]                    rd_word;
    logic [7:0]                     rd_byte;
    logic [15:0]                    rd_half;
    logic [31:0]                    load_data;
    logic [31:0]                    resp_data;
    logic                           wr_en;
    logic [3:0]                     wr_be;
    logic [31:0]                    wr_data;

    assign accept = req_i && (lsu_opcode_i != `LSU_NONE);

    // With zero latency the response is formed in the accept cycle, so the
    // request is taken straight from the ports; otherwise from the latched copy.
    always_comb begin
        if (state_q == StIdle) begin
            cur_op    = lsu_opcode_i;
            cur_addr  = val_memaddr_i;
            cur_wdata = val_memdatawr_i;
        end else begin
            cur_op    = op_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign enter_resp = ((state_q == StIdle) && accept && (LATENCY == 0)) ||
                        ((state_q == StWait) && (cnt_q == '0));

    always_comb begin
        is_half  = 1'b0;
        is_word  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        case (cur_op)
            `LSU_LB:  sign_ext = 1'b1;
            `LSU_LH:  begin is_half = 1'b1; sign_ext = 1'b1; end
            `LSU_LW:  is_word = 1'b1;
            `LSU_LHU: is_half = 1'b1;
            `LSU_SB:  is_store = 1'b1;
            `LSU_SH:  begin is_half = 1'b1; is_store = 1'b1; end
            `LSU_SW:  begin is_word = 1'b1; is_store = 1'b1; end
            default:  ;
        endcase
    end

    assign misaligned   = (is_half && cur_addr[0]) || (is_word && (cur_addr[1:0] != 2'b00));
    assign out_of_range = {2'b00, cur_addr[31:2]} >= DEPTH;
    assign cur_err      = misaligned || out_of_range;
    assign word_idx     = cur_addr[IdxW+1:2];
    assign rd_word      = mem[word_idx];

    always_comb begin
        case (cur_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
        if (is_word) begin
            load_data = rd_word;
        end else if (is_half) begin
            load_data = {{16{sign_ext & rd_half[15]}}, rd_half};
        end else begin
            load_data = {{24{sign_ext & rd_byte[7]}}, rd_byte};
        end
    end

    assign resp_data = (cur_err || is_store) ? 32'h0 : load_data;

    always_comb begin
        if (is_word) begin
            wr_be   = 4'b1111;
            wr_data = cur_wdata;
        end else if (is_half) begin
            wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
            wr_data = {2{cur_wdata[15:0]}};
        end else begin
            wr_be   = 4'b0001 << cur_addr[1:0];
            wr_data = {4{cur_wdata[7:0]}};
        end
    end

    // The write lands on the edge entering RESP, so a reset during WAIT drops it.
    assign wr_en = enter_resp && is_store && !cur_err;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= `LSU_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            if (enter_resp) begin
                ack_q   <= 1'b1;
                err_q   <= cur_err;
                rdata_q <= resp_data;
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= lsu_opcode_i;
                        addr_q  <= val_memaddr_i;
                        wdata_q <= val_memdatawr_i;
                        busy_q  <= 1'b1;
                        if (LATENCY == 0) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CNT_WIDTH'(LATENCY - 1);
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign val_memdatard_o = rdata_q;
    assign ack_o           = ack_q;
    assign err_o           = err_q;
    assign busy_o          = busy_q;

endmodule

// File: tb/tb_rv32im_dmem.sv
// Directed bench for rv32im_dmem: three instances with LATENCY 0, 1 and 3
// share data/address/opcode inputs and reset, each with its own request line.

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif
`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif
`ifndef LSU_NONE
`define LSU_NONE 4'd0
`define LSU_LB   4'd1
`define LSU_LH   4'd2
`define LSU_LW   4'd3
`define LSU_LBU  4'd4
`define LSU_LHU  4'd5
`define LSU_SB   4'd6
`define LSU_SH   4'd7
`define LSU_SW   4'd8
`endif

module tb_rv32im_dmem;

    logic        clk;
    logic        rst_n;
    logic        req0, req1, req3;
    logic [3:0]  op;
    logic [31:0] addr, wdata;
    logic [31:0] rd0, rd1, rd3;
    logic        ack0, ack1, ack3;
    logic        err0, err1, err3;
    logic        busy0, busy1, busy3;

    int checks;
    int passed;
    int sel;

    logic        ack_m, err_m, busy_m;
    logic [31:0] rd_m;

    always_comb begin
        case (sel)
            0:       begin ack_m = ack0; err_m = err0; busy_m = busy0; rd_m = rd0; end
            3:       begin ack_m = ack3; err_m = err3; busy_m = busy3; rd_m = rd3; end
            default: begin ack_m = ack1; err_m = err1; busy_m = busy1; rd_m = rd1; end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rv32im_dmem #(.DEPTH(1024), .LATENCY(0), .CNT_WIDTH(4)) u_lat0 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req0), .lsu_opcode_i(op),
        .val_memaddr_i(addr), .val_memdatawr_i(wdata), .val_memdatard_o(rd0),
        .ack_o(ack0), .err_o(err0), .busy_o(busy0)
    );

    rv32im_dmem #(.DEPTH(1024), .LATENCY(1), .CNT_WIDTH(4)) u_lat1 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req1), .lsu_opcode_i(op),
        .val_memaddr_i(addr), .val_memdatawr_i(wdata), .val_memdatard_o(rd1),
        .ack_o(ack1), .err_o(err1), .busy_o(busy1)
    );

    rv32im_dmem #(.DEPTH(1024), .LATENCY(3), .CNT_WIDTH(4)) u_lat3 (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req3), .lsu_opcode_i(op),
        .val_memaddr_i(addr), .val_memdatawr_i(wdata), .val_memdatard_o(rd3),
        .ack_o(ack3), .err_o(err3), .busy_o(busy3)
    );

    task automatic set_req(input int s, input logic v);
        case (s)
            0:       req0 = v;
            3:       req3 = v;
            default: req1 = v;
        endcase
    endtask

    // One request; lat is the ack cycle counted from the accept cycle (0 = no ack).
    task automatic run_txn(input int s, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] r, output logic e,
                           output int lat, output int bsy);
        sel = s;
        @(negedge clk);
        op = o; addr = a; wdata = d;
        set_req(s, 1'b1);
        @(negedge clk);
        set_req(s, 1'b0);
        op = `LSU_NONE; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        r = '0; e = 1'b0; lat = 0; bsy = 0;
        for (int i = 1; i <= 20; i++) begin
            if (busy_m) bsy++;
            if (ack_m) begin
                lat = i; r = rd_m; e = err_m;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (busy_m) bsy++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (ack1 !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ack1); else passed++;
        checks++; if (err1 !== 1'b0) $display("FAIL reset_err: got %b expected 0", err1); else passed++;
        checks++; if (busy1 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy1); else passed++;
        checks++; if (rd1 !== 32'h0) $display("FAIL reset_rdata: got %h expected 0", rd1); else passed++;
        checks++; if (busy3 !== 1'b0) $display("FAIL reset_busy3: got %b expected 0", busy3); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        logic [31:0] r; logic e; int lat, bsy;
        run_txn(1, `LSU_SW, 32'h10, 32'hDEADBEEF, r, e, lat, bsy);
        checks++; if (lat !== 2) $display("FAIL sw_latency: got %0d expected 2", lat); else passed++;
        checks++; if (bsy !== 2) $display("FAIL sw_busy_cycles: got %0d expected 2", bsy); else passed++;
        checks++; if (e !== 1'b0 || r !== 32'h0) $display("FAIL sw_resp: got err %b data %h expected 0/0", e, r); else passed++;
        run_txn(1, `LSU_LW, 32'h10, 32'h0, r, e, lat, bsy);
        checks++; if (lat !== 2) $display("FAIL lw_latency: got %0d expected 2", lat); else passed++;
        checks++; if (r !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL lw_data: got %h err %b expected deadbeef/0", r, e); else passed++;
    endtask

    task automatic test_byte_half();
        logic [3:0]  ops [7];
        logic [31:0] adrs [7];
        logic [31:0] exps [7];
        logic [31:0] r; logic e; int lat, bsy;
        ops = '{`LSU_LW, `LSU_LB, `LSU_LBU, `LSU_LH, `LSU_LHU, `LSU_LB, `LSU_LHU};
        adrs = '{32'h10, 32'h12, 32'h12, 32'h12, 32'h12, 32'h10, 32'h10};
        exps = '{32'hDE80BEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFFDE80, 32'h0000DE80,
                 32'hFFFFFFEF, 32'h0000BEEF};
        run_txn(1, `LSU_SB, 32'h12, 32'h1234_5680, r, e, lat, bsy);
        checks++; if (e !== 1'b0) $display("FAIL sb_err: got %b expected 0", e); else passed++;
        for (int i = 0; i < 7; i++) begin
            run_txn(1, ops[i], adrs[i], 32'h0, r, e, lat, bsy);
            checks++;
            if (r !== exps[i] || e !== 1'b0)
                $display("FAIL load_ext_%0d: got %h err %b expected %h/0", i, r, e, exps[i]);
            else passed++;
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] r; logic e; int lat, bsy;
        run_txn(1, `LSU_LH, 32'h11, 32'h0, r, e, lat, bsy);
        checks++; if (e !== 1'b1 || r !== 32'h0 || lat !== 2) $display("FAIL lh_misaligned: got err %b data %h lat %0d expected 1/0/2", e, r, lat); else passed++;
        run_txn(1, `LSU_SW, 32'h12, 32'h12345678, r, e, lat, bsy);
        checks++; if (e !== 1'b1) $display("FAIL sw_misaligned: got err %b expected 1", e); else passed++;
        run_txn(1, `LSU_SH, 32'h13, 32'h0000AAAA, r, e, lat, bsy);
        checks++; if (e !== 1'b1) $display("FAIL sh_misaligned: got err %b expected 1", e); else passed++;
        run_txn(1, `LSU_LW, 32'h10, 32'h0, r, e, lat, bsy);
        checks++; if (r !== 32'hDE80BEEF || e !== 1'b0) $display("FAIL misaligned_no_write: got %h expected de80beef", r); else passed++;
    endtask

    task automatic test_out_of_range();
        logic [31:0] r; logic e; int lat, bsy;
        run_txn(1, `LSU_SW, 32'hFFC, 32'h13579BDF, r, e, lat, bsy);
        checks++; if (e !== 1'b0) $display("FAIL sw_last_word_err: got %b expected 0", e); else passed++;
        run_txn(1, `LSU_LW, 32'hFFC, 32'h0, r, e, lat, bsy);
        checks++; if (r !== 32'h13579BDF || e !== 1'b0) $display("FAIL lw_last_word: got %h err %b expected 13579bdf/0", r, e); else passed++;
        run_txn(1, `LSU_LW, 32'h1000, 32'h0, r, e, lat, bsy);
        checks++; if (e !== 1'b1 || r !== 32'h0) $display("FAIL lw_out_of_range: got err %b data %h expected 1/0", e, r); else passed++;
        run_txn(1, `LSU_SB, 32'h8000_0000, 32'h0, r, e, lat, bsy);
        checks++; if (e !== 1'b1) $display("FAIL sb_out_of_range: got err %b expected 1", e); else passed++;
    endtask

    task automatic test_latency();
        logic [31:0] r; logic e; int lat, bsy;
        run_txn(0, `LSU_SW, 32'h40, 32'h11223344, r, e, lat, bsy);
        checks++; if (lat !== 1) $display("FAIL lat0_latency: got %0d expected 1", lat); else passed++;
        checks++; if (bsy !== 1) $display("FAIL lat0_busy_cycles: got %0d expected 1", bsy); else passed++;
        run_txn(0, `LSU_LH, 32'h42, 32'h0, r, e, lat, bsy);
        checks++; if (r !== 32'h00001122 || lat !== 1) $display("FAIL lat0_lh: got %h lat %0d expected 00001122/1", r, lat); else passed++;
        run_txn(3, `LSU_SW, 32'h40, 32'h8899AABB, r, e, lat, bsy);
        checks++; if (lat !== 4) $display("FAIL lat3_latency: got %0d expected 4", lat); else passed++;
        checks++; if (bsy !== 4) $display("FAIL lat3_busy_cycles: got %0d expected 4", bsy); else passed++;
        run_txn(3, `LSU_LH, 32'h40, 32'h0, r, e, lat, bsy);
        checks++; if (r !== 32'hFFFFAABB || lat !== 4) $display("FAIL lat3_lh: got %h lat %0d expected ffffaabb/4", r, lat); else passed++;
    endtask

    task automatic test_back_to_back(input int s, input int l);
        int n, acks, bad_gap, last;
        n = 4 * (l + 2); acks = 0; bad_gap = 0; last = -1;
        sel = s;
        @(negedge clk);
        op = `LSU_LW; addr = 32'h40; wdata = 32'h0;
        set_req(s, 1'b1);
        for (int k = 0; k < n + l + 4; k++) begin
            if (k == n) set_req(s, 1'b0);
            if (ack_m) begin
                acks++;
                if (last >= 0 && (k - last) != l + 2) bad_gap++;
                last = k;
            end
            @(negedge clk);
        end
        op = `LSU_NONE;
        checks++; if (acks !== 4) $display("FAIL b2b_ack_count_lat%0d: got %0d expected 4", l, acks); else passed++;
        checks++; if (bad_gap !== 0) $display("FAIL b2b_spacing_lat%0d: got %0d bad gaps expected 0", l, bad_gap); else passed++;
    endtask

    // Inputs switch to a different request during WAIT; the first transaction must
    // complete untouched and the second is taken only in the cycle after RESP.
    task automatic test_change_in_wait();
        int first_k, second_k, acks;
        logic [31:0] first_r, second_r;
        first_k = -1; second_k = -1; acks = 0; first_r = '0; second_r = '0;
        sel = 3;
        @(negedge clk);
        op = `LSU_SW; addr = 32'h50; wdata = 32'hCAFEF00D; req3 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 1) begin op = `LSU_LW; wdata = 32'h0; end
            if (k == 6) begin req3 = 1'b0; op = `LSU_NONE; end
            if (ack3) begin
                acks++;
                if (first_k < 0) begin first_k = k; first_r = rd3; end
                else begin second_k = k; second_r = rd3; end
            end
            @(negedge clk);
        end
        checks++; if (first_k !== 4 || first_r !== 32'h0) $display("FAIL wait_first_ack: got cycle %0d data %h expected 4/0", first_k, first_r); else passed++;
        checks++; if (second_k !== 9) $display("FAIL wait_second_accept: got cycle %0d expected 9", second_k); else passed++;
        checks++; if (second_r !== 32'hCAFEF00D) $display("FAIL wait_store_kept: got %h expected cafef00d", second_r); else passed++;
        checks++; if (acks !== 2) $display("FAIL wait_ack_count: got %0d expected 2", acks); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] r; logic e; int lat, bsy, late_acks;
        run_txn(3, `LSU_SW, 32'h20, 32'h0, r, e, lat, bsy);
        @(negedge clk);
        op = `LSU_SW; addr = 32'h20; wdata = 32'hA5A5A5A5; req3 = 1'b1;
        @(negedge clk);
        req3 = 1'b0; op = `LSU_NONE;
        @(negedge clk);
        checks++; if (busy3 !== 1'b1) $display("FAIL mid_busy_before_reset: got %b expected 1", busy3); else passed++;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (busy3 !== 1'b0 || ack3 !== 1'b0) $display("FAIL mid_async_reset: got busy %b ack %b expected 0/0", busy3, ack3); else passed++;
        late_acks = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ack3) late_acks++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ack3) late_acks++;
        end
        checks++; if (late_acks !== 0) $display("FAIL mid_no_ack: got %0d acks expected 0", late_acks); else passed++;
        run_txn(3, `LSU_LW, 32'h20, 32'h0, r, e, lat, bsy);
        checks++; if (r !== 32'h0 || lat !== 4) $display("FAIL mid_store_discarded: got %h lat %0d expected 0/4", r, lat); else passed++;
    endtask

    initial begin
        checks = 0; passed = 0; sel = 1;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; req3 = 1'b0;
        op = `LSU_NONE; addr = '0; wdata = '0;
        test_reset();
        test_store_load();
        test_byte_half();
        test_misaligned();
        test_out_of_range();
        test_latency();
        test_back_to_back(1, 1);
        test_back_to_back(3, 3);
        test_change_in_wait();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", passed, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
